// File: rtl/conv_mac_engine.sv
// conv_mac_engine: K-tap multi-channel convolution MAC with bias, rounding shift, ReLU and saturation.
// Four register stages (input, multiply/tree, accumulate, requantise) all advance on a single global enable.
module conv_mac_engine #(
    parameter int DATA_WIDTH      = 8,
    parameter int WGT_WIDTH       = 8,
    parameter int TAPS            = 9,
    parameter int ACC_WIDTH       = 24,
    parameter int OUT_WIDTH       = 8,
    parameter int CH_CNT_W        = 8,
    parameter int SHIFT_W         = 5,
    parameter int INPUT_IS_SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CH_CNT_W-1:0]           cfg_num_ch,
    input  logic [SHIFT_W-1:0]            cfg_shift,
    input  logic                          cfg_relu,
    input  logic [ACC_WIDTH-1:0]          bias,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH*TAPS-1:0]    window_data,
    input  logic [WGT_WIDTH*TAPS-1:0]     weights,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [ACC_WIDTH-1:0]          out_acc
);
    localparam int AW = DATA_WIDTH + 1;
    localparam int RW = ACC_WIDTH + 1;
    localparam logic signed [RW-1:0] OMAX = RW'(2 ** (OUT_WIDTH - 1) - 1);
    localparam logic signed [RW-1:0] OMIN = ~OMAX;

    logic adv, accept, first, last;
    logic [CH_CNT_W-1:0] ch_cnt, num_ch_q, num_eff, num_cur;
    logic [SHIFT_W-1:0] shift_q, shift_cur, shift_s1, shift_s2, shift_s3;
    logic relu_q, relu_cur, relu_s1, relu_s2, relu_s3;
    logic [TAPS*AW-1:0] act_ext, act_s1;
    logic [TAPS*WGT_WIDTH-1:0] wgt_s1;
    logic valid_s1, last_s1, first_s1, valid_s2, last_s2, first_s2, valid_s3;
    logic signed [ACC_WIDTH-1:0] bias_s1, bias_s2, psum, psum_s2, acc, sum, t_s3;
    logic signed [RW-1:0] half, r, rq, sat;

    assign adv      = !out_valid || out_ready;
    assign in_ready = rst_n && adv;
    assign accept   = in_valid && in_ready;

    // Group config is taken live on the first beat and from the latched copy afterwards.
    always_comb begin
        first     = ch_cnt == '0;
        num_eff   = (cfg_num_ch == '0) ? CH_CNT_W'(1) : cfg_num_ch;
        num_cur   = first ? num_eff : num_ch_q;
        shift_cur = first ? cfg_shift : shift_q;
        relu_cur  = first ? cfg_relu : relu_q;
        last      = ch_cnt == num_cur - CH_CNT_W'(1);
        act_ext   = '0;
        for (int i = 0; i < TAPS; i++)
            act_ext[i*AW +: AW] = {(INPUT_IS_SIGNED != 0) && window_data[i*DATA_WIDTH + DATA_WIDTH - 1],
                                   window_data[i*DATA_WIDTH +: DATA_WIDTH]};
    end

    always_comb begin
        psum = '0;
        for (int i = 0; i < TAPS; i++)
            psum = psum + ACC_WIDTH'($signed(act_s1[i*AW +: AW]))
                        * ACC_WIDTH'($signed(wgt_s1[i*WGT_WIDTH +: WGT_WIDTH]));
    end

    // Rounding is done one bit wider than the accumulator so the half-LSB add cannot wrap.
    always_comb begin
        sum  = (first_s2 ? '0 : acc) + psum_s2;
        half = (shift_s3 == '0) ? '0 : RW'(1) << (shift_s3 - SHIFT_W'(1));
        r    = (RW'(t_s3) + half) >>> shift_s3;
        rq   = (relu_s3 && r[RW-1]) ? '0 : r;
        sat  = (rq > OMAX) ? OMAX : (rq < OMIN) ? OMIN : rq;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt   <= '0;
            num_ch_q <= CH_CNT_W'(1);
            shift_q  <= '0;
            relu_q   <= 1'b0;
        end else if (accept) begin
            ch_cnt <= last ? '0 : ch_cnt + CH_CNT_W'(1);
            if (first) begin
                num_ch_q <= num_eff;
                shift_q  <= cfg_shift;
                relu_q   <= cfg_relu;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_s1  <= 1'b0;
            valid_s2  <= 1'b0;
            valid_s3  <= 1'b0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_acc   <= '0;
        end else if (adv) begin
            valid_s1  <= accept;
            valid_s2  <= valid_s1;
            valid_s3  <= valid_s2 && last_s2;
            if (valid_s2)
                acc <= last_s2 ? '0 : sum;
            out_valid <= valid_s3;
            if (valid_s3) begin
                out_acc  <= t_s3;
                out_data <= OUT_WIDTH'(sat);
            end
        end
    end

    // Datapath registers carry no reset; their qualifying valids do.
    always_ff @(posedge clk) begin
        if (adv) begin
            act_s1   <= act_ext;
            wgt_s1   <= weights;
            last_s1  <= last;
            first_s1 <= first;
            bias_s1  <= bias;
            shift_s1 <= shift_cur;
            relu_s1  <= relu_cur;
            psum_s2  <= psum;
            last_s2  <= last_s1;
            first_s2 <= first_s1;
            bias_s2  <= bias_s1;
            shift_s2 <= shift_s1;
            relu_s2  <= relu_s1;
            t_s3     <= sum + bias_s2;
            shift_s3 <= shift_s2;
            relu_s3  <= relu_s2;
        end
    end
endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: unsigned and signed-input engines driven in parallel, checked against
// a per-group arithmetic model plus directed corner cases.
module tb_conv_mac_engine;
    logic clk = 1'b0;
    logic rst_n, in_valid, out_ready, cfg_relu;
    logic [7:0] cfg_num_ch;
    logic [4:0] cfg_shift;
    logic [23:0] bias;
    logic [71:0] window_data, weights;
    logic in_ready_u, in_ready_s, out_valid_u, out_valid_s;
    logic [7:0] out_data_u, out_data_s;
    logic [23:0] out_acc_u, out_acc_s;

    int n_tests = 0, n_fail = 0, n_out = 0;
    bit rand_rdy = 1'b0;

    typedef struct {
        longint acc_u;
        longint dat_u;
        longint acc_s;
        longint dat_s;
    } exp_t;
    exp_t q[$];

    int m_cnt = 0, m_num = 1, m_sh = 0;
    bit m_relu = 1'b0;
    longint m_acc_u = 0, m_acc_s = 0;

    always #5 clk = ~clk;

    conv_mac_engine #(.INPUT_IS_SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .cfg_num_ch(cfg_num_ch), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .bias(bias), .in_valid(in_valid), .in_ready(in_ready_u),
        .window_data(window_data), .weights(weights), .out_valid(out_valid_u),
        .out_ready(out_ready), .out_data(out_data_u), .out_acc(out_acc_u));

    conv_mac_engine #(.INPUT_IS_SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_num_ch(cfg_num_ch), .cfg_shift(cfg_shift),
        .cfg_relu(cfg_relu), .bias(bias), .in_valid(in_valid), .in_ready(in_ready_s),
        .window_data(window_data), .weights(weights), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_acc(out_acc_s));

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] rep(input logic [7:0] x);
        return {9{x}};
    endfunction

    function automatic longint beat_sum(input logic [71:0] w, input logic [71:0] k, input bit sgn);
        longint s = 0, a;
        for (int i = 0; i < 9; i++) begin
            if (sgn) a = longint'($signed(w[i*8 +: 8]));
            else     a = longint'(w[i*8 +: 8]);
            s += a * longint'($signed(k[i*8 +: 8]));
        end
        return s;
    endfunction

    function automatic longint wrap24(input longint x);
        longint y = x & 64'hFF_FFFF;
        return (y >= 64'h80_0000) ? y - 64'h100_0000 : y;
    endfunction

    function automatic longint requant(input longint t, input int sh, input bit rl);
        longint r = (sh == 0) ? t : (t + (longint'(1) << (sh - 1))) >>> sh;
        if (rl && r < 0) r = 0;
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    // Reference model: groups formed from accepted beats, one expected result per completed group.
    initial forever begin
        exp_t e;
        @(posedge clk);
        if (!rst_n) begin
            m_cnt = 0;
            q.delete();
        end else if (in_valid && in_ready_u) begin
            if (m_cnt == 0) begin
                m_num   = (cfg_num_ch == 0) ? 1 : int'(cfg_num_ch);
                m_sh    = int'(cfg_shift);
                m_relu  = cfg_relu;
                m_acc_u = 0;
                m_acc_s = 0;
            end
            m_acc_u += beat_sum(window_data, weights, 1'b0);
            m_acc_s += beat_sum(window_data, weights, 1'b1);
            m_cnt++;
            if (m_cnt == m_num) begin
                e.acc_u = wrap24(m_acc_u + longint'($signed(bias)));
                e.acc_s = wrap24(m_acc_s + longint'($signed(bias)));
                e.dat_u = requant(e.acc_u, m_sh, m_relu);
                e.dat_s = requant(e.acc_s, m_sh, m_relu);
                q.push_back(e);
                m_cnt = 0;
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && out_valid_u && out_ready) begin
            n_out++;
            check("valid_s", out_valid_s, 1);
            if (q.size() == 0) check("unexpected_out", 1, 0);
            else begin
                e = q.pop_front();
                check("acc_u", longint'($signed(out_acc_u)), e.acc_u);
                check("dat_u", longint'($signed(out_data_u)), e.dat_u);
                check("acc_s", longint'($signed(out_acc_s)), e.acc_s);
                check("dat_s", longint'($signed(out_data_s)), e.dat_s);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [71:0] w, input logic [71:0] k, input logic [7:0] n,
                        input logic [4:0] sh, input logic rl, input logic [23:0] b);
        bit ok = 1'b0;
        window_data = w; weights = k; cfg_num_ch = n; cfg_shift = sh; cfg_relu = rl; bias = b;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            if (in_ready_u) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid_u) return;
        end
        check("out_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int c, c2, n0;
        logic [71:0] w, k;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cfg_num_ch = 8'd1; cfg_shift = '0; cfg_relu = 1'b0; bias = '0;
        window_data = '0; weights = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready_u, 0);
        check("rst_out_valid", out_valid_u, 0);
        check("rst_out_data", out_data_u, 0);
        check("rst_out_acc", out_acc_u, 0);
        rst_n = 1'b1;
        #1 check("in_ready_after_rst", in_ready_u, 1);

        send(rep(8'd255), rep(8'd127), 8'd1, 5'd10, 1'b0, 24'd0);
        wait_out(c);
        check("t1_latency", c, 3);
        check("t1_acc", out_acc_u, 291465);
        check("t1_data", longint'($signed(out_data_u)), 127);
        idle(4);

        send(rep(8'h80), rep(8'd127), 8'd1, 5'd10, 1'b0, 24'd0);
        wait_out(c);
        check("t2_acc_s", longint'($signed(out_acc_s)), -146304);
        check("t2_data_s", longint'($signed(out_data_s)), -128);
        check("t2_data_u", longint'($signed(out_data_u)), 127);
        idle(4);
        send(rep(8'h80), rep(8'd127), 8'd1, 5'd10, 1'b1, 24'd0);
        wait_out(c);
        check("t2_relu_s", longint'($signed(out_data_s)), 0);
        idle(4);

        n0 = n_out;
        repeat (3) send(rep(8'd1), rep(8'd1), 8'd3, 5'd2, 1'b0, 24'd5);
        wait_out(c);
        check("t3_latency", c, 3);
        check("t3_acc", out_acc_u, 32);
        check("t3_data", out_data_u, 8);
        idle(4);
        check("t3_one_output", n_out - n0, 1);

        n0 = n_out;
        fork
            begin
                repeat (2) send(rep(8'd2), rep(8'd3), 8'd2, 5'd1, 1'b0, 24'd10);
                repeat (2) send(rep(8'd1), rep(8'hFF), 8'd2, 5'd1, 1'b0, 24'd10);
                repeat (2) send(rep(8'd3), rep(8'd1), 8'd2, 5'd1, 1'b0, 24'd10);
            end
            begin
                wait_out(c2);
                out_ready = 1'b0;
                #1;
                check("t4_in_ready_drop", in_ready_u, 0);
                check("t4_in_ready_drop_s", in_ready_s, 0);
                repeat (4) @(posedge clk);
                #1;
                check("t4_hold_valid", out_valid_u, 1);
                check("t4_hold_acc", out_acc_u, 118);
                check("t4_hold_data", out_data_u, 59);
                check("t4_stall_ready", in_ready_u, 0);
                out_ready = 1'b1;
            end
        join
        idle(8);
        check("t4_outputs", n_out - n0, 3);

        n0 = n_out;
        send(rep(8'd1), rep(8'd1), 8'd3, 5'd0, 1'b0, 24'd0);
        send(rep(8'd1), rep(8'd1), 8'd1, 5'd3, 1'b0, 24'd0);
        send(rep(8'd1), rep(8'd1), 8'd1, 5'd3, 1'b0, 24'd0);
        wait_out(c);
        check("t5_latency", c, 3);
        check("t5_data", out_data_u, 27);
        idle(3);
        send(rep(8'd2), rep(8'd1), 8'd1, 5'd0, 1'b0, 24'd0);
        wait_out(c);
        check("t5_single_latency", c, 3);
        check("t5_single_data", out_data_u, 18);
        idle(3);
        check("t5_outputs", n_out - n0, 2);

        n0 = n_out;
        repeat (2) send(rep(8'd1), rep(8'd1), 8'd3, 5'd0, 1'b0, 24'd7);
        rst_n = 1'b0;
        #1 check("t6_rst_valid", out_valid_u, 0);
        idle(2);
        rst_n = 1'b1;
        #1;
        repeat (3) send(rep(8'd1), rep(8'd1), 8'd3, 5'd0, 1'b0, 24'd7);
        wait_out(c);
        check("t6_acc", out_acc_u, 34);
        check("t6_data", out_data_u, 34);
        idle(4);
        check("t6_outputs", n_out - n0, 1);

        rand_rdy = 1'b1;
        for (int b = 0; b < 300; b++) begin
            for (int i = 0; i < 9; i++) begin
                w[i*8 +: 8] = 8'($urandom_range(0, 255));
                k[i*8 +: 8] = 8'($urandom_range(0, 255));
            end
            send(w, k, 8'($urandom_range(0, 4)), 5'($urandom_range(0, 16)),
                 1'($urandom_range(0, 1)), 24'($urandom));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        rand_rdy = 1'b0;
        #1 out_ready = 1'b1;
        idle(12);
        check("scoreboard_drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
